// File: rtl/isqrt_fsm.sv
// Iterative 32-bit integer square root, radix-4 digit recurrence, P result bits per clock.
// Optional ISQRT_FSM_SMALL_SHORTCUT_EN: radicands 0..3 skip the compute phase.
module isqrt_fsm #(
  parameter int unsigned P = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        x_vld,
  input  logic [31:0] x,
  output logic        y_vld,
  output logic [15:0] y,
  output logic        busy
);

  localparam int unsigned K     = 16 / P;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    st_idle,
    st_calc,
    st_done
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        xs_q, xs_d;
  logic [17:0]        rem_q, rem_d;
  logic [15:0]        root_q, root_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        y_q, y_d;
  logic               y_vld_q, y_vld_d;
  logic               busy_q, busy_d;

  logic [31:0]        xs_v;
  logic [17:0]        rem_v;
  logic [17:0]        trial_v;
  logic [15:0]        root_v;

  // P recurrence steps per clock; rem never exceeds 16 bits before the shift
  always_comb begin
    xs_v    = xs_q;
    rem_v   = rem_q;
    root_v  = root_q;
    trial_v = '0;
    for (int i = 0; i < int'(P); i++) begin
      rem_v   = {rem_v[15:0], xs_v[31:30]};
      xs_v    = {xs_v[29:0], 2'b00};
      trial_v = {root_v, 2'b01};
      if (rem_v >= trial_v) begin
        rem_v  = rem_v - trial_v;
        root_v = {root_v[14:0], 1'b1};
      end else begin
        root_v = {root_v[14:0], 1'b0};
      end
    end
  end

  always_comb begin
    state_d = state_q;
    xs_d    = xs_q;
    rem_d   = rem_q;
    root_d  = root_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    y_vld_d = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      st_idle, st_done: begin
        busy_d  = 1'b0;
        state_d = st_idle;
        if (x_vld) begin
`ifdef ISQRT_FSM_SMALL_SHORTCUT_EN
          if (x[31:2] == 30'd0) begin
            state_d = st_done;
            y_d     = {15'd0, |x[1:0]};
            y_vld_d = 1'b1;
          end else begin
            xs_d    = x;
            rem_d   = '0;
            root_d  = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = st_calc;
          end
`else
          xs_d    = x;
          rem_d   = '0;
          root_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = st_calc;
`endif
        end
      end
      st_calc: begin
        xs_d   = xs_v;
        rem_d  = rem_v;
        root_d = root_v;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(K - 1)) begin
          state_d = st_done;
          y_d     = root_v;
          y_vld_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = st_idle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= st_idle;
      xs_q    <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      y_vld_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xs_q    <= xs_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      y_vld_q <= y_vld_d;
      busy_q  <= busy_d;
    end
  end

  assign y     = y_q;
  assign y_vld = y_vld_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_isqrt_fsm.sv
// Directed bench for isqrt_fsm: P=1, P=4 and P=16 instances on shared inputs.
module tb_isqrt_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        x_vld;
  logic [31:0] x;
  logic        y_vld1, y_vld4, y_vld16;
  logic [15:0] y1, y4, y16;
  logic        busy1, busy4, busy16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  isqrt_fsm #(.P(1))  dut1  (.clk(clk), .rst(rst), .x_vld(x_vld), .x(x),
                             .y_vld(y_vld1),  .y(y1),  .busy(busy1));
  isqrt_fsm #(.P(4))  dut4  (.clk(clk), .rst(rst), .x_vld(x_vld), .x(x),
                             .y_vld(y_vld4),  .y(y4),  .busy(busy4));
  isqrt_fsm #(.P(16)) dut16 (.clk(clk), .rst(rst), .x_vld(x_vld), .x(x),
                             .y_vld(y_vld16), .y(y16), .busy(busy16));

`ifdef ISQRT_FSM_SMALL_SHORTCUT_EN
  localparam bit SHORTCUT = 1'b1;
`else
  localparam bit SHORTCUT = 1'b0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pick(input int sel, output logic v, output logic [15:0] yy, output logic b);
    case (sel)
      4:       begin v = y_vld4;  yy = y4;  b = busy4;  end
      16:      begin v = y_vld16; yy = y16; b = busy16; end
      default: begin v = y_vld1;  yy = y1;  b = busy1;  end
    endcase
  endtask

  // One request; optional x_vld injection and reset at given cycles; 40-cycle window
  task automatic measure(input int sel, input logic [31:0] xv,
                         input int inj_cyc, input logic [31:0] inj_x, input int rst_cyc,
                         output int lat, output logic [15:0] y_first, output int pulses,
                         output int b_first, output int b_last, output int b_cnt,
                         output logic [15:0] y_end);
    logic v, b;
    logic [15:0] yy;
    lat = -1; y_first = '0; pulses = 0; b_first = -1; b_last = -1; b_cnt = 0;
    x_vld = 1'b1;
    x     = xv;
    step();
    for (int n = 1; n <= 40; n++) begin
      x_vld = (n == inj_cyc);
      x     = (n == inj_cyc) ? inj_x : ~xv;
      rst   = (n == rst_cyc);
      pick(sel, v, yy, b);
      if (v) begin
        pulses++;
        if (lat < 0) begin
          lat     = n;
          y_first = yy;
        end
      end
      if (b) begin
        b_cnt++;
        if (b_first < 0) b_first = n;
        b_last = n;
      end
      step();
    end
    x_vld = 1'b0;
    rst   = 1'b0;
    pick(sel, v, y_end, b);
  endtask

  task automatic test_reset();
    rst = 1'b1; x_vld = 1'b0; x = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    total++; if (y_vld1 !== 1'b0) begin bad++; $display("FAIL reset_y_vld got=%b want=0", y_vld1); end
    total++; if (y1 !== 16'd0)    begin bad++; $display("FAIL reset_y got=%0d want=0", y1); end
    total++; if (busy1 !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%b want=0", busy1); end
    total++; if (busy4 !== 1'b0 || y4 !== 16'd0) begin
      bad++; $display("FAIL reset_p4 got busy=%b y=%0d want busy=0 y=0", busy4, y4);
    end
  endtask

  task automatic test_basic();
    int lat, pulses, bf, bl, bc;
    logic [15:0] yf, ye;
    measure(1, 32'd16, -1, '0, -1, lat, yf, pulses, bf, bl, bc, ye);
    total++; if (lat !== 17)    begin bad++; $display("FAIL basic_lat got=%0d want=17", lat); end
    total++; if (yf !== 16'd4)  begin bad++; $display("FAIL basic_y got=%0d want=4", yf); end
    total++; if (pulses !== 1)  begin bad++; $display("FAIL basic_pulses got=%0d want=1", pulses); end
    total++; if (bf !== 1 || bl !== 16 || bc !== 16) begin
      bad++; $display("FAIL basic_busy got first=%0d last=%0d cnt=%0d want 1 16 16", bf, bl, bc);
    end
  endtask

  task automatic test_sweep();
    logic [31:0] xs [5] = '{32'd0, 32'd1, 32'd15, 32'hFFFF_FFFF, 32'd4294836225};
    logic [15:0] ys [5] = '{16'd0, 16'd1, 16'd3, 16'd65535, 16'd65535};
    int lat, pulses, bf, bl, bc, want_lat;
    logic [15:0] yf, ye;
    for (int i = 0; i < 5; i++) begin
      measure(1, xs[i], -1, '0, -1, lat, yf, pulses, bf, bl, bc, ye);
      want_lat = (SHORTCUT && xs[i] < 32'd4) ? 1 : 17;
      total++; if (lat !== want_lat || yf !== ys[i] || pulses !== 1) begin
        bad++;
        $display("FAIL sweep x=%0d got lat=%0d y=%0d pulses=%0d want lat=%0d y=%0d pulses=1",
                 xs[i], lat, yf, pulses, want_lat, ys[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int c1, c2;
    c1 = -1; c2 = -1;
    x_vld = 1'b1; x = 32'd100;
    step();
    x_vld = 1'b0; x = 32'hDEAD_BEEF;
    for (int n = 1; n <= 40; n++) begin
      if (y_vld1) begin c1 = n; break; end
      step();
    end
    total++; if (c1 !== 17 || y1 !== 16'd10) begin
      bad++; $display("FAIL b2b_first got lat=%0d y=%0d want lat=17 y=10", c1, y1);
    end
    x_vld = 1'b1; x = 32'd4294836225;
    step();
    x_vld = 1'b0; x = 32'd0;
    total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL b2b_gap busy got=%b want=1", busy1); end
    for (int n = 1; n <= 40; n++) begin
      if (y_vld1) begin c2 = n; break; end
      step();
    end
    total++; if (c2 !== 17 || y1 !== 16'd65535) begin
      bad++; $display("FAIL b2b_second got lat=%0d y=%0d want lat=17 y=65535", c2, y1);
    end
    repeat (3) step();
  endtask

  task automatic test_busy_ignore();
    int lat, pulses, bf, bl, bc, held_bad;
    logic [15:0] yf, ye;
    measure(1, 32'd144, 5, 32'd9, -1, lat, yf, pulses, bf, bl, bc, ye);
    total++; if (pulses !== 1 || lat !== 17 || yf !== 16'd12) begin
      bad++; $display("FAIL busy_ignore got pulses=%0d lat=%0d y=%0d want 1 17 12", pulses, lat, yf);
    end
    held_bad = 0;
    for (int n = 0; n < 20; n++) begin
      if (y1 !== 16'd12 || y_vld1 !== 1'b0) held_bad++;
      step();
    end
    total++; if (held_bad !== 0) begin
      bad++; $display("FAIL y_hold got bad_cycles=%0d y=%0d want bad_cycles=0 y=12", held_bad, y1);
    end
  endtask

  task automatic test_mid_reset();
    int lat, pulses, bf, bl, bc;
    logic [15:0] yf, ye;
    measure(1, 32'd1000, -1, '0, 8, lat, yf, pulses, bf, bl, bc, ye);
    total++; if (pulses !== 0) begin bad++; $display("FAIL rst_no_strobe got pulses=%0d want=0", pulses); end
    total++; if (ye !== 16'd0 || busy1 !== 1'b0) begin
      bad++; $display("FAIL rst_state got y=%0d busy=%b want y=0 busy=0", ye, busy1);
    end
    measure(1, 32'd49, -1, '0, -1, lat, yf, pulses, bf, bl, bc, ye);
    total++; if (lat !== 17 || yf !== 16'd7 || pulses !== 1) begin
      bad++; $display("FAIL rst_recover got lat=%0d y=%0d pulses=%0d want 17 7 1", lat, yf, pulses);
    end
  endtask

  task automatic test_wide_p();
    int lat, pulses, bf, bl, bc;
    logic [15:0] yf, ye;
    measure(4, 32'd1000000, -1, '0, -1, lat, yf, pulses, bf, bl, bc, ye);
    total++; if (lat !== 5 || yf !== 16'd1000 || pulses !== 1) begin
      bad++; $display("FAIL p4_main got lat=%0d y=%0d pulses=%0d want 5 1000 1", lat, yf, pulses);
    end
    measure(4, 32'd3, -1, '0, -1, lat, yf, pulses, bf, bl, bc, ye);
    total++; if (lat !== (SHORTCUT ? 1 : 5) || yf !== 16'd1 || bc !== (SHORTCUT ? 0 : 4)) begin
      bad++; $display("FAIL p4_small got lat=%0d y=%0d busy_cnt=%0d want lat=%0d y=1 busy_cnt=%0d",
                      lat, yf, bc, SHORTCUT ? 1 : 5, SHORTCUT ? 0 : 4);
    end
    measure(16, 32'd4294836225, -1, '0, -1, lat, yf, pulses, bf, bl, bc, ye);
    total++; if (lat !== 2 || yf !== 16'd65535 || pulses !== 1) begin
      bad++; $display("FAIL p16_main got lat=%0d y=%0d pulses=%0d want 2 65535 1", lat, yf, pulses);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sweep();
    test_back_to_back();
    test_busy_ignore();
    test_mid_reset();
    test_wide_p();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
